// File: rtl/leg_pkg.sv
// Shared types for the dispatch scheduler: register/station ids,
// the registered dispatch payload and small helpers.
package leg_pkg;

  localparam int DEF_NUM_STATIONS = 4;
  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_REG_W        = $clog2(DEF_NUM_REGS);
  localparam int STATION_W        = 4;
  localparam int ALU_FN_W         = 6;
  localparam int IMM_W            = 16;

  typedef logic [DEF_REG_W-1:0] reg_idx_t;
  typedef logic [STATION_W-1:0] station_id_t;

  localparam station_id_t STATION_NONE = '0;

  typedef struct packed {
    logic [ALU_FN_W-1:0] alu_fn;
    reg_idx_t            reg1;
    reg_idx_t            reg2;
    reg_idx_t            target;
    logic                has_r1;
    logic                has_r2;
    logic                has_target;
    logic [IMM_W-1:0]    immediate;
  } dispatch_payload_t;

  function automatic logic station_legal(
    input station_id_t st,
    input int          n
  );
    return (st != STATION_NONE) && (int'(st) <= n);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Decoder-side op handshake and station-side dispatch bundle.
// slave = scheduler view, master = producer/station view.
interface dispatch_scheduler_if #(
  parameter int NUM_STATIONS = 4,
  parameter int REG_W        = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_rs_station;
  logic [5:0]       in_alu_fn;
  logic [REG_W-1:0] in_reg1;
  logic [REG_W-1:0] in_reg2;
  logic             in_has_r1;
  logic             in_has_r2;
  logic [REG_W-1:0] in_target;
  logic             in_has_target;
  logic [15:0]      in_immediate;

  logic [NUM_STATIONS-1:0] disp_valid;
  logic [NUM_STATIONS-1:0] disp_ready;
  logic [5:0]              disp_alu_fn;
  logic [REG_W-1:0]        disp_reg1;
  logic [REG_W-1:0]        disp_reg2;
  logic [REG_W-1:0]        disp_target;
  logic                    disp_has_r1;
  logic                    disp_has_r2;
  logic                    disp_has_target;
  logic [15:0]             disp_immediate;

  modport slave (
    input  in_valid, in_rs_station, in_alu_fn,
    input  in_reg1, in_reg2, in_has_r1, in_has_r2,
    input  in_target, in_has_target, in_immediate,
    output in_ready,
    output disp_valid, disp_alu_fn,
    output disp_reg1, disp_reg2, disp_target,
    output disp_has_r1, disp_has_r2, disp_has_target,
    output disp_immediate,
    input  disp_ready
  );

  modport master (
    output in_valid, in_rs_station, in_alu_fn,
    output in_reg1, in_reg2, in_has_r1, in_has_r2,
    output in_target, in_has_target, in_immediate,
    input  in_ready,
    input  disp_valid, disp_alu_fn,
    input  disp_reg1, disp_reg2, disp_target,
    input  disp_has_r1, disp_has_r2, disp_has_target,
    input  disp_immediate,
    output disp_ready
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Register busy vector with writeback bypass; set wins over a
// same-cycle clear. r0 is never busy.
module reg_scoreboard
  import leg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_reg,
  input  logic                clr_en,
  input  logic [REG_W-1:0]    clr_reg,
  input  logic                flush_clr_en,
  input  logic [REG_W-1:0]    flush_clr_reg,
  input  logic                has_r1,
  input  logic [REG_W-1:0]    reg1,
  input  logic                has_r2,
  input  logic [REG_W-1:0]    reg2,
  input  logic                has_target,
  input  logic [REG_W-1:0]    target,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] eff_busy;

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  assign clr_mask = clr_en ? (ONE << clr_reg) : '0;
  assign eff_busy = busy_q & ~clr_mask;

  assign hazard = (has_r1 & eff_busy[reg1])
                | (has_r2 & eff_busy[reg2])
                | (has_target & eff_busy[target]);

  always_comb begin
    busy_d = busy_q;
    if (clr_en)
      busy_d[clr_reg] = 1'b0;
    if (flush_clr_en)
      busy_d[flush_clr_reg] = 1'b0;
    if (set_en)
      busy_d[set_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/dispatch_scheduler.sv
// Hazard-checked one-slot dispatch to reservation stations.
// Optional perf counters: define DISPATCH_PERF_EN.
module dispatch_scheduler
  import leg_pkg::*;
#(
  parameter int NUM_STATIONS = DEF_NUM_STATIONS,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int REG_W        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dispatch_scheduler_if.slave  bus,
  input  logic                 wb_valid,
  input  logic [REG_W-1:0]     wb_reg,
  input  logic                 flush,
  output logic                 illegal_op,
  output logic [NUM_REGS-1:0]  busy_regs
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_dispatched,
  output logic [31:0]          perf_hazard_stall,
  output logic [31:0]          perf_station_stall
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q;
  state_t                  state_d;
  dispatch_payload_t       in_pl;
  dispatch_payload_t       slot_q;
  dispatch_payload_t       slot_d;
  logic [NUM_STATIONS-1:0] dv_q;
  logic [NUM_STATIONS-1:0] dv_d;
  logic [NUM_STATIONS-1:0] in_onehot;
  logic                    legal;
  logic                    hazard;
  logic                    fire;
  logic                    accept;
  logic                    acc_legal;
  logic                    acc_illegal;
  logic                    go_flush;
  logic                    go_drain;
  logic                    illegal_q;
  logic                    sb_set;
  logic                    sb_flush_clr;

  assign in_pl = '{
    alu_fn:     bus.in_alu_fn,
    reg1:       bus.in_reg1,
    reg2:       bus.in_reg2,
    target:     bus.in_target,
    has_r1:     bus.in_has_r1,
    has_r2:     bus.in_has_r2,
    has_target: bus.in_has_target,
    immediate:  bus.in_immediate
  };

  assign legal = station_legal(bus.in_rs_station, NUM_STATIONS);
  assign fire  = |(dv_q & bus.disp_ready);

  // illegal ops never touch the scoreboard, so they bypass the hazard hold
  assign bus.in_ready = !flush
                      && !(legal && hazard)
                      && ((state_q == EMPTY) || fire);

  assign accept      = bus.in_valid && bus.in_ready;
  assign acc_legal   = accept && legal;
  assign acc_illegal = accept && !legal;
  assign go_flush    = flush;
  assign go_drain    = fire && !flush && !acc_legal;

  always_comb begin
    in_onehot = '0;
    for (int i = 0; i < NUM_STATIONS; i++)
      in_onehot[i] = (bus.in_rs_station == station_id_t'(i + 1));
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    dv_d    = dv_q;
    unique case (1'b1)
      go_flush: begin
        state_d = EMPTY;
        slot_d  = '0;
        dv_d    = '0;
      end
      acc_legal: begin
        state_d = FULL;
        slot_d  = in_pl;
        dv_d    = in_onehot;
      end
      go_drain: begin
        state_d = EMPTY;
        dv_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      dv_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      dv_q      <= dv_d;
      illegal_q <= acc_illegal;
    end
  end

  assign sb_set = acc_legal
               && bus.in_has_target
               && (bus.in_target != '0);

  // a flushed op that did not fire will never write back
  assign sb_flush_clr = flush
                     && (state_q == FULL)
                     && !fire
                     && slot_q.has_target;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en        (sb_set),
    .set_reg       (bus.in_target),
    .clr_en        (wb_valid),
    .clr_reg       (wb_reg),
    .flush_clr_en  (sb_flush_clr),
    .flush_clr_reg (slot_q.target),
    .has_r1        (bus.in_has_r1),
    .reg1          (bus.in_reg1),
    .has_r2        (bus.in_has_r2),
    .reg2          (bus.in_reg2),
    .has_target    (bus.in_has_target),
    .target        (bus.in_target),
    .hazard        (hazard),
    .busy          (busy_regs)
  );

  assign bus.disp_valid      = dv_q;
  assign bus.disp_alu_fn     = slot_q.alu_fn;
  assign bus.disp_reg1       = slot_q.reg1;
  assign bus.disp_reg2       = slot_q.reg2;
  assign bus.disp_target     = slot_q.target;
  assign bus.disp_has_r1     = slot_q.has_r1;
  assign bus.disp_has_r2     = slot_q.has_r2;
  assign bus.disp_has_target = slot_q.has_target;
  assign bus.disp_immediate  = slot_q.immediate;
  assign illegal_op          = illegal_q;

`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dispatched    <= '0;
      perf_hazard_stall  <= '0;
      perf_station_stall <= '0;
    end else begin
      perf_dispatched    <= sat_inc(perf_dispatched, fire);
      perf_hazard_stall  <= sat_inc(perf_hazard_stall,
                                    bus.in_valid && hazard);
      perf_station_stall <= sat_inc(perf_station_stall,
                                    (state_q == FULL) && !fire);
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard bench for dispatch_scheduler: expected dispatches are
// queued on accept and compared when a station takes them.
module tb_dispatch_scheduler;
  import leg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic        illegal_op;
  logic [31:0] busy_regs;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_dispatched;
  logic [31:0] perf_hazard_stall;
  logic [31:0] perf_station_stall;
`endif

  int passed = 0;
  int total  = 0;
  int fires  = 0;

  typedef struct {
    logic [3:0]  dv;
    logic [39:0] pl;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  dispatch_scheduler_if #(.NUM_STATIONS(4), .REG_W(5)) bus ();

  dispatch_scheduler #(
    .NUM_STATIONS (4),
    .NUM_REGS     (32),
    .REG_W        (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .flush      (flush),
    .illegal_op (illegal_op),
    .busy_regs  (busy_regs)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_dispatched    (perf_dispatched),
    .perf_hazard_stall  (perf_hazard_stall),
    .perf_station_stall (perf_station_stall)
`endif
  );

  function automatic logic [39:0] disp_pl();
    return {bus.disp_alu_fn, bus.disp_reg1, bus.disp_reg2,
            bus.disp_target, bus.disp_has_r1, bus.disp_has_r2,
            bus.disp_has_target, bus.disp_immediate};
  endfunction

  function automatic logic [39:0] in_pl();
    return {bus.in_alu_fn, bus.in_reg1, bus.in_reg2,
            bus.in_target, bus.in_has_r1, bus.in_has_r2,
            bus.in_has_target, bus.in_immediate};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(bus.disp_valid & bus.disp_ready)) begin
        fires++;
        total++;
        if (q.size() == 0) begin
          $display("FAIL dispatch_unexpected got dv=%b expected none",
                   bus.disp_valid);
        end else begin
          e = q.pop_front();
          if ({bus.disp_valid, disp_pl()} !== {e.dv, e.pl})
            $display("FAIL dispatch_payload got %b/%h expected %b/%h",
                     bus.disp_valid, disp_pl(), e.dv, e.pl);
          else
            passed++;
        end
      end
      if (bus.in_valid && bus.in_ready
          && bus.in_rs_station >= 4'd1
          && bus.in_rs_station <= 4'd4) begin
        e.dv = 4'b0001 << (bus.in_rs_station - 4'd1);
        e.pl = in_pl();
        q.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_rs_station = '0;
    bus.in_alu_fn     = '0;
    bus.in_reg1       = '0;
    bus.in_reg2       = '0;
    bus.in_has_r1     = 1'b0;
    bus.in_has_r2     = 1'b0;
    bus.in_target     = '0;
    bus.in_has_target = 1'b0;
    bus.in_immediate  = '0;
  endtask

  task automatic drive(
    input logic [3:0]  st,
    input logic [4:0]  r1,
    input logic        h1,
    input logic [4:0]  r2,
    input logic        h2,
    input logic [4:0]  tg,
    input logic        ht,
    input logic [15:0] imm
  );
    bus.in_valid      = 1'b1;
    bus.in_rs_station = st;
    bus.in_alu_fn     = imm[5:0] ^ 6'h15;
    bus.in_reg1       = r1;
    bus.in_has_r1     = h1;
    bus.in_reg2       = r2;
    bus.in_has_r2     = h2;
    bus.in_target     = tg;
    bus.in_has_target = ht;
    bus.in_immediate  = imm;
  endtask

  task automatic test_reset();
    idle();
    wb_valid = 1'b0;
    wb_reg = '0;
    flush = 1'b0;
    bus.disp_ready = 4'b1111;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.disp_valid !== 4'b0)
      $display("FAIL reset_dv got %b expected 0", bus.disp_valid);
    else passed++;
    total++;
    if ({illegal_op, busy_regs} !== 33'b0)
      $display("FAIL reset_flags got %b/%h expected 0/0",
               illegal_op, busy_regs);
    else passed++;
    total++;
    if (disp_pl() !== 40'b0)
      $display("FAIL reset_payload got %h expected 0", disp_pl());
    else passed++;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    bus.disp_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      drive(4'd1, 5'd2, 1'b1, 5'd0, 1'b0, 5'(10 + i), 1'b1,
            16'(100 + i));
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL b2b_in_ready got %b expected 1", bus.in_ready);
      else passed++;
      if (i > 0) begin
        total++;
        if (bus.disp_valid !== 4'b0001)
          $display("FAIL b2b_dv got %b expected 0001", bus.disp_valid);
        else passed++;
      end
    end
    step();
    idle();
    @(negedge clk);
    total++;
    if ({bus.disp_valid, busy_regs} !== {4'b0001, 32'h0000_3C00})
      $display("FAIL b2b_last got %b/%h expected 0001/00003c00",
               bus.disp_valid, busy_regs);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (bus.disp_valid !== 4'b0)
      $display("FAIL b2b_drain got %b expected 0", bus.disp_valid);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      wb_valid = 1'b1;
      wb_reg = 5'(10 + i);
    end
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy_regs !== 32'h0)
      $display("FAIL b2b_wb_clear got %h expected 0", busy_regs);
    else passed++;
  endtask

  task automatic test_raw_wb();
    step();
    drive(4'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 16'h0500);
    step();
    drive(4'd4, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 16'h0600);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0)
        $display("FAIL raw_hold got %b expected 0", bus.in_ready);
      else passed++;
      step();
    end
    wb_valid = 1'b1;
    wb_reg = 5'd5;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL raw_wb_bypass got %b expected 1", bus.in_ready);
    else passed++;
    step();
    idle();
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.disp_valid, busy_regs} !== {4'b1000, 32'h0000_0040})
      $display("FAIL raw_after got %b/%h expected 1000/00000040",
               bus.disp_valid, busy_regs);
    else passed++;
    step();
    wb_valid = 1'b1;
    wb_reg = 5'd6;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [39:0] held;
    bus.disp_ready = 4'b1101;
    step();
    drive(4'd2, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 16'hBEEF);
    held = {6'h2F ^ 6'h15, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0,
            16'hBEEF};
    step();
    drive(4'd1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus.disp_valid, bus.in_ready, disp_pl()}
          !== {4'b0010, 1'b0, held})
        $display("FAIL stall_hold got %b/%b/%h expected 0010/0/%h",
                 bus.disp_valid, bus.in_ready, disp_pl(), held);
      else passed++;
      step();
    end
    bus.disp_ready = 4'b1111;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL stall_release got %b expected 1", bus.in_ready);
    else passed++;
    step();
    idle();
    @(negedge clk);
    total++;
    if (bus.disp_valid !== 4'b0001)
      $display("FAIL stall_next got %b expected 0001", bus.disp_valid);
    else passed++;
    step();
  endtask

  task automatic test_illegal();
    logic [3:0] sts [2];
    sts[0] = 4'd0;
    sts[1] = 4'd5;
    bus.disp_ready = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      drive(sts[i], 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 16'h0900);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL illegal_ready got %b expected 1", bus.in_ready);
      else passed++;
      step();
      idle();
      @(negedge clk);
      total++;
      if ({illegal_op, bus.disp_valid, busy_regs}
          !== {1'b1, 4'b0, 32'h0})
        $display("FAIL illegal_pulse got %b/%b/%h expected 1/0000/0",
                 illegal_op, bus.disp_valid, busy_regs);
      else passed++;
      step();
      @(negedge clk);
      total++;
      if (illegal_op !== 1'b0)
        $display("FAIL illegal_once got %b expected 0", illegal_op);
      else passed++;
    end
  endtask

  task automatic test_flush();
    bus.disp_ready = 4'b1011;
    step();
    drive(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 16'h0300);
    step();
    drive(4'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 16'h0700);
    step();
    idle();
    @(negedge clk);
    total++;
    if ({bus.disp_valid, busy_regs} !== {4'b0100, 32'h0000_0088})
      $display("FAIL flush_pre got %b/%h expected 0100/00000088",
               bus.disp_valid, busy_regs);
    else passed++;
    step();
    drive(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0001);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL flush_ready got %b expected 0", bus.in_ready);
    else passed++;
    void'(q.pop_back());
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    total++;
    if ({bus.disp_valid, busy_regs} !== {4'b0000, 32'h0000_0008})
      $display("FAIL flush_post got %b/%h expected 0000/00000008",
               bus.disp_valid, busy_regs);
    else passed++;
    step();
    wb_valid = 1'b1;
    wb_reg = 5'd3;
    step();
    wb_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.disp_ready = 4'b0000;
    step();
    drive(4'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 16'h0C0C);
    step();
    idle();
    @(negedge clk);
    total++;
    if ({bus.disp_valid, busy_regs} !== {4'b0010, 32'h0000_1000})
      $display("FAIL areset_pre got %b/%h expected 0010/00001000",
               bus.disp_valid, busy_regs);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.disp_valid, illegal_op, busy_regs, disp_pl()} !== 77'b0)
      $display("FAIL areset got %b/%b/%h/%h expected all 0",
               bus.disp_valid, illegal_op, busy_regs, disp_pl());
    else passed++;
    q.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw_wb();
    test_stall();
    test_illegal();
    test_flush();
    total++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain got %0d expected 0", q.size());
    else passed++;
`ifdef DISPATCH_PERF_EN
    total++;
    if (perf_dispatched !== 32'(fires))
      $display("FAIL perf_dispatched got %0d expected %0d",
               perf_dispatched, fires);
    else passed++;
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
